ez8_boot_ctrl: RTL and testbench
================================

EZ8_BOOT_CTRL -- requirements
Module: ez8_boot_ctrl

Interface
REQ-001 Parameter: ADDR_W, 12, instruction memory address width.
REQ-002 Parameter: INSTR_W, 16, instruction word width.
REQ-003 Ports: clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Ports: reset_n  input  1  reset; synchronous, active-low.
REQ-005 Ports: start  input  1  one-cycle request to begin a load-and-run session; honoured only in IDLE or DONE.
REQ-006 Ports: run_cycles  input  16  CPU run budget in clocks, latched on accepted start; 0 = run until stop.
REQ-007 Ports: stop  input  1  forces the RUN state to end.
REQ-008 Ports: rx_data  input  8  boot byte stream; rx_valid  input  1; rx_ready  output  1.
REQ-009 Ports: instr_writeaddr  output  ADDR_W; instr_writedata  output  INSTR_W; instr_write_en  output  1  CPU instruction-memory write port.
REQ-010 Ports: cpu_reset  output  1  active-high CPU reset; cpu_pause  output  1  CPU pause.
REQ-011 Ports: accum_in  input  8  CPU accumulator; result  output  8; done  output  1; busy  output  1.

Function
REQ-012 States SHALL be IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CPU_RST, RUN, DONE.
REQ-013 Accepted start SHALL go to ADDR_HI, latch run_cycles, clear done; start in any other state SHALL be ignored.
REQ-014 A byte SHALL transfer only on a cycle with rx_valid and rx_ready both high; rx_ready SHALL be high only in ADDR_HI..DATA_LO.
REQ-015 Header order: start address (hi, lo), then word count (hi, lo), big-endian; upper 4 bits of each hi byte ignored.
REQ-016 Count 0 SHALL skip from CNT_LO directly to CPU_RST.
REQ-017 Each instruction SHALL arrive as hi byte then lo byte; after lo byte, WRITE SHALL assert instr_write_en for exactly one cycle with current address and assembled word.
REQ-018 After WRITE: address increments modulo 2^ADDR_W (0xFFF wraps to 0x000), count decrements; count reaching 0 -> CPU_RST, else DATA_HI.
REQ-019 instr_write_en SHALL be low in every state except WRITE.
REQ-020 cpu_pause SHALL be 1 in all states except CPU_RST and RUN.
REQ-021 CPU_RST SHALL last one cycle with cpu_reset=1, cpu_pause=0; cpu_reset SHALL be 0 elsewhere.
REQ-022 RUN: a 16-bit counter counts cycles from 1; leave RUN when counter equals latched nonzero budget, or when stop is high (stop wins on the same cycle).
REQ-023 On leaving RUN: cpu_pause=1 next cycle, enter DONE; result SHALL capture accum_in on the first DONE cycle.
REQ-024 done SHALL be high throughout DONE, low elsewhere; result holds until the next capture.
REQ-025 busy SHALL be high in every state except IDLE and DONE.
REQ-026 stop outside RUN SHALL have no effect.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force IDLE, from any state including mid-load or RUN.
REQ-028 Reset values: rx_ready=0, instr_write_en=0, instr_writeaddr=0, instr_writedata=0, cpu_reset=0, cpu_pause=1, result=0, done=0, busy=0, counters 0.

Structure
REQ-029 ez8_pkg SHALL hold the state enum, ADDR_W/INSTR_W defaults and byte-order constants.
REQ-030 Byte-to-word assembly SHALL be a sub-module ez8_byte_assembler (hi/lo latch, word-ready pulse).

Verification
REQ-031 start, run_cycles=10, bytes 00 00 00 02 40 50 01 01 -> writes (0x000,0x4050) then (0x001,0x0101), one cycle each, then one cpu_reset cycle.
REQ-032 Start address 0x0FFF, count 2 -> writes at 0xFFF then 0x000.
REQ-033 Count 0 -> no instr_write_en; CPU_RST immediately after CNT_LO.
REQ-034 run_cycles=5, accum_in=7 -> cpu_pause low exactly 5 RUN cycles, done=1, result=0x07.
REQ-035 run_cycles=0, stop pulsed after 20 RUN cycles -> RUN ends, done=1; stop in IDLE ignored.
REQ-036 reset_n low mid-DATA_LO and mid-RUN -> next cycle IDLE, cpu_pause=1, instr_write_en=0, rx_ready=0.

Source files
------------

// File: rtl/ez8_pkg.sv
// Shared types and constants for the EZ8 boot controller: FSM state encoding,
// default bus widths and the byte order used to assemble instruction words.
package ez8_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_INSTR_W = 16;
    localparam int BYTE_W      = 8;
    localparam int CNT_W       = 12;

    // Big-endian stream: the first byte of each word lands in the upper lane.
    localparam int WORD_HI_LANE = 1;
    localparam int WORD_LO_LANE = 0;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CPU_RST,
        RUN,
        DONE
    } state_t;

    function automatic logic is_rx_state(input state_t s);
        return s inside {ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO};
    endfunction

endpackage

// File: rtl/ez8_boot_ctrl_if.sv
// Boot byte stream (valid/ready) plus the CPU instruction-memory write port.
// The host/testbench side uses master; the boot controller uses slave.
interface ez8_boot_ctrl_if #(
    parameter int ADDR_W  = ez8_pkg::DEF_ADDR_W,
    parameter int INSTR_W = ez8_pkg::DEF_INSTR_W
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [ADDR_W-1:0]  instr_writeaddr;
    logic [INSTR_W-1:0] instr_writedata;
    logic               instr_write_en;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, instr_writeaddr, instr_writedata, instr_write_en
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, instr_writeaddr, instr_writedata, instr_write_en
    );
endinterface

// File: rtl/ez8_byte_assembler.sv
// Collects a hi byte and a lo byte into one instruction word; word_ready pulses
// for one cycle after the lo byte, while the assembled word is held stable.
module ez8_byte_assembler
    import ez8_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [BYTE_W-1:0]  byte_data,
    input  logic               hi_load,
    input  logic               lo_load,
    output logic [INSTR_W-1:0] word,
    output logic               word_ready
);
    localparam int LANES = INSTR_W / BYTE_W;

    logic [LANES-1:0] lane_load;
    logic             word_ready_reg;

    always_comb begin
        lane_load               = '0;
        lane_load[WORD_HI_LANE] = hi_load;
        lane_load[WORD_LO_LANE] = lo_load;
    end

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_reg;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                lane_reg <= '0;
            end else if (lane_load[gi]) begin
                lane_reg <= byte_data;
            end
        end

        assign word[gi*BYTE_W +: BYTE_W] = lane_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_ready_reg <= 1'b0;
        end else begin
            word_ready_reg <= lo_load;
        end
    end

    assign word_ready = word_ready_reg;

endmodule

// File: rtl/ez8_boot_ctrl.sv
// Boot controller: receives a header and instruction words over a byte stream,
// writes them into CPU instruction memory, then resets and runs the CPU.
module ez8_boot_ctrl
    import ez8_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] run_cycles,
    input  logic        stop,
    input  logic [7:0]  accum_in,
    output logic        cpu_reset,
    output logic        cpu_pause,
    output logic [7:0]  result,
    output logic        done,
    output logic        busy,
    ez8_boot_ctrl_if.slave bus
);
    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [15:0]        budget_reg;
    logic [15:0]        run_cnt_reg;
    logic               first_done_reg;
    logic [7:0]         result_reg;
    logic               rx_ready_reg;
    logic               cpu_reset_reg;
    logic               cpu_pause_reg;
    logic               done_reg;
    logic               busy_reg;

    logic               xfer;
    logic               hdr_cnt_zero;
    logic [INSTR_W-1:0] word;
    logic               word_ready;

    assign xfer         = bus.rx_valid && rx_ready_reg;
    assign hdr_cnt_zero = (cnt_reg[CNT_W-1:8] == '0) && (bus.rx_data == 8'h00);

    ez8_byte_assembler #(
        .INSTR_W (INSTR_W)
    ) u_assembler (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_data  (bus.rx_data),
        .hi_load    ((state_reg == DATA_HI) && xfer),
        .lo_load    ((state_reg == DATA_LO) && xfer),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = ADDR_HI;
            ADDR_HI:    if (xfer) state_next = ADDR_LO;
            ADDR_LO:    if (xfer) state_next = CNT_HI;
            CNT_HI:     if (xfer) state_next = CNT_LO;
            CNT_LO:     if (xfer) state_next = hdr_cnt_zero ? CPU_RST : DATA_HI;
            DATA_HI:    if (xfer) state_next = DATA_LO;
            DATA_LO:    if (xfer) state_next = WRITE;
            WRITE:      state_next = (cnt_reg == CNT_W'(1)) ? CPU_RST : DATA_HI;
            CPU_RST:    state_next = RUN;
            // stop and budget expiry both lead to DONE, so stop's priority is implicit
            RUN: begin
                if (stop || ((budget_reg != '0) && (run_cnt_reg == budget_reg))) begin
                    state_next = DONE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            budget_reg     <= '0;
            run_cnt_reg    <= '0;
            first_done_reg <= 1'b0;
            result_reg     <= '0;
            rx_ready_reg   <= 1'b0;
            cpu_reset_reg  <= 1'b0;
            cpu_pause_reg  <= 1'b1;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rx_ready_reg   <= is_rx_state(state_next);
            cpu_reset_reg  <= (state_next == CPU_RST);
            cpu_pause_reg  <= !(state_next inside {CPU_RST, RUN});
            done_reg       <= (state_next == DONE);
            busy_reg       <= !(state_next inside {IDLE, DONE});
            first_done_reg <= (state_reg == RUN) && (state_next == DONE);

            if (first_done_reg) begin
                result_reg <= accum_in;
            end

            case (state_reg)
                IDLE, DONE: if (start) budget_reg <= run_cycles;
                ADDR_HI:    if (xfer) addr_reg[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
                ADDR_LO:    if (xfer) addr_reg[7:0] <= bus.rx_data;
                CNT_HI:     if (xfer) cnt_reg[CNT_W-1:8] <= bus.rx_data[CNT_W-9:0];
                CNT_LO:     if (xfer) cnt_reg[7:0] <= bus.rx_data;
                WRITE: begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                end
                CPU_RST:    run_cnt_reg <= 16'd1;
                RUN:        run_cnt_reg <= run_cnt_reg + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready        = rx_ready_reg;
    assign bus.instr_writeaddr = addr_reg;
    assign bus.instr_writedata = word;
    assign bus.instr_write_en  = word_ready;

    assign cpu_reset = cpu_reset_reg;
    assign cpu_pause = cpu_pause_reg;
    assign result    = result_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_ez8_boot_ctrl.sv
// Bench for ez8_boot_ctrl: table of directed load-and-run sessions, randomized
// sessions against a session-level model, and hand-written reset/stop sequences.
module tb_ez8_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] run_cycles = 16'd0;
    logic [7:0]  accum_in = 8'd0;
    logic        cpu_reset;
    logic        cpu_pause;
    logic [7:0]  result;
    logic        done;
    logic        busy;

    ez8_boot_ctrl_if bus_if ();

    ez8_boot_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .run_cycles (run_cycles),
        .stop       (stop),
        .accum_in   (accum_in),
        .cpu_reset  (cpu_reset),
        .cpu_pause  (cpu_pause),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rst_obs = 0;
    int obs_run = 0;
    logic [27:0] wr_q[$];

    // Monitor: every write-enable cycle is one memory write.
    always @(negedge clk) begin
        if (bus_if.instr_write_en) wr_q.push_back({bus_if.instr_writeaddr, bus_if.instr_writedata});
        if (cpu_reset) rst_obs++;
    end

    typedef struct {
        logic [11:0] addr;
        logic [11:0] cnt;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] budget;
        int          stop_after;
        logic [7:0]  accum;
        int          exp_nwr;
        logic [11:0] exp_a0;
        logic [11:0] exp_a1;
        int          exp_run;
        logic [7:0]  exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int model_run(input int budget, input int stop_after);
        if (budget == 0) return stop_after;
        if (stop_after == 0 || budget < stop_after) return budget;
        return stop_after;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus_if.rx_valid = 1'b0;
                bus_if.rx_data  = 8'($urandom);
                start = ($urandom_range(0, 3) == 0);
                stop  = ($urandom_range(0, 3) == 0);
                tick();
                start = 1'b0;
                stop  = 1'b0;
            end
        end
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        guard = 0;
        while (!bus_if.rx_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("rx_ready_wait", 32'(bus_if.rx_ready), 1);
        tick();
    endtask

    task automatic load_only(input logic [11:0] addr, input logic [11:0] cnt,
                             input logic [15:0] words[$], input logic [15:0] budget,
                             input logic [7:0] accum, input bit gaps);
        logic [7:0] bytes[$];
        logic [3:0] junk;
        junk = gaps ? 4'($urandom) : 4'h0;
        bytes.push_back({junk, addr[11:8]});
        bytes.push_back(addr[7:0]);
        bytes.push_back({junk, cnt[11:8]});
        bytes.push_back(cnt[7:0]);
        foreach (words[i]) begin
            bytes.push_back(words[i][15:8]);
            bytes.push_back(words[i][7:0]);
        end
        wr_q.delete();
        rst_obs    = 0;
        run_cycles = budget;
        accum_in   = accum;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        run_cycles = 16'($urandom);
        chk("start_busy", 32'(busy), 1);
        chk("start_done_clr", 32'(done), 0);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
        bus_if.rx_valid = 1'b0;
        if (cnt != 12'd0) begin
            chk("write_pulse", 32'(bus_if.instr_write_en), 1);
            tick();
            chk("write_one_cycle", 32'(bus_if.instr_write_en), 0);
        end
        chk("cpu_rst_after_load", 32'(cpu_reset), 1);
        chk("cpu_rst_unpaused", 32'(cpu_pause), 0);
    endtask

    task automatic run_phase(input int stop_after);
        int guard;
        bit stopped;
        obs_run = 0;
        guard   = 0;
        stopped = 1'b0;
        while (!done && guard < 3000) begin
            if (!cpu_pause && !cpu_reset) obs_run++;
            if (stop_after != 0 && obs_run == stop_after && !stopped) begin
                stop    = 1'b1;
                stopped = 1'b1;
            end
            tick();
            stop = 1'b0;
            guard++;
        end
        chk("done_wait", 32'(done), 1);
        tick();
        chk("done_held", 32'(done), 1);
        chk("done_not_busy", 32'(busy), 0);
        chk("done_paused", 32'(cpu_pause), 1);
    endtask

    task automatic do_session(input int id, input logic [11:0] addr, input logic [11:0] cnt,
                              input logic [15:0] words[$], input logic [15:0] budget,
                              input int stop_after, input logic [7:0] accum, input bit gaps,
                              input logic [27:0] exp_wr[$], input int exp_run,
                              input logic [7:0] exp_res);
        load_only(addr, cnt, words, budget, accum, gaps);
        run_phase(stop_after);
        chk("run_length", 32'(obs_run), 32'(exp_run));
        chk("result", 32'(result), 32'(exp_res));
        chk("cpu_rst_cycles", 32'(rst_obs), 1);
        chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            chk("wr_addr", 32'(wr_q[i][27:16]), 32'(exp_wr[i][27:16]));
            chk("wr_data", 32'(wr_q[i][15:0]), 32'(exp_wr[i][15:0]));
        end
        $display("session %0d: addr=%03h cnt=%0d budget=%0d stop_after=%0d -> writes=%0d run=%0d result=%02h",
                 id, addr, cnt, budget, stop_after, wr_q.size(), obs_run, result);
    endtask

    initial begin
        logic [15:0] wq[$];
        logic [27:0] eq[$];
        logic [11:0] addr;
        logic [11:0] cnt;
        logic [15:0] budget;
        int          stop_after;
        logic [7:0]  accum;

        vecs[0] = '{12'h000, 12'd2, 16'h4050, 16'h0101, 16'd10, 0,  8'h3C, 2, 12'h000, 12'h001, 10, 8'h3C};
        vecs[1] = '{12'hFFF, 12'd2, 16'hBEEF, 16'h1234, 16'd3,  0,  8'h5A, 2, 12'hFFF, 12'h000, 3,  8'h5A};
        vecs[2] = '{12'h345, 12'd0, 16'h0000, 16'h0000, 16'd4,  0,  8'h81, 0, 12'h000, 12'h000, 4,  8'h81};
        vecs[3] = '{12'h123, 12'd1, 16'h0F0F, 16'h0000, 16'd5,  0,  8'h07, 1, 12'h123, 12'h000, 5,  8'h07};
        vecs[4] = '{12'h200, 12'd1, 16'h5555, 16'h0000, 16'd0,  20, 8'hA5, 1, 12'h200, 12'h000, 20, 8'hA5};
        vecs[5] = '{12'h7FE, 12'd2, 16'hAAAA, 16'h5555, 16'd8,  3,  8'hC3, 2, 12'h7FE, 12'h7FF, 3,  8'hC3};
        vecs[6] = '{12'h0FF, 12'd1, 16'h8001, 16'h0000, 16'd1,  0,  8'hFF, 1, 12'h0FF, 12'h000, 1,  8'hFF};

        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;

        // Reset values
        repeat (3) tick();
        chk("rst_rx_ready", 32'(bus_if.rx_ready), 0);
        chk("rst_write_en", 32'(bus_if.instr_write_en), 0);
        chk("rst_waddr", 32'(bus_if.instr_writeaddr), 0);
        chk("rst_wdata", 32'(bus_if.instr_writedata), 0);
        chk("rst_cpu_reset", 32'(cpu_reset), 0);
        chk("rst_cpu_pause", 32'(cpu_pause), 1);
        chk("rst_result", 32'(result), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Stop in IDLE has no effect
        stop = 1'b1;
        repeat (3) tick();
        stop = 1'b0;
        chk("idle_stop_busy", 32'(busy), 0);
        chk("idle_stop_done", 32'(done), 0);
        chk("idle_stop_pause", 32'(cpu_pause), 1);
        chk("idle_stop_ready", 32'(bus_if.rx_ready), 0);

        for (int v = 0; v < 7; v++) begin
            wq.delete();
            eq.delete();
            if (vecs[v].cnt > 12'd0) wq.push_back(vecs[v].w0);
            if (vecs[v].cnt > 12'd1) wq.push_back(vecs[v].w1);
            if (vecs[v].exp_nwr > 0) eq.push_back({vecs[v].exp_a0, vecs[v].w0});
            if (vecs[v].exp_nwr > 1) eq.push_back({vecs[v].exp_a1, vecs[v].w1});
            do_session(v, vecs[v].addr, vecs[v].cnt, wq, vecs[v].budget, vecs[v].stop_after,
                       vecs[v].accum, 1'b0, eq, vecs[v].exp_run, vecs[v].exp_res);
        end

        // Reset while waiting for the lo byte of a word
        run_cycles = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_q.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        chk("dlo_ready", 32'(bus_if.rx_ready), 1);
        bus_if.rx_data = 8'h34;
        reset_n = 1'b0;
        tick();
        chk("dlo_rst_write_en", 32'(bus_if.instr_write_en), 0);
        chk("dlo_rst_rx_ready", 32'(bus_if.rx_ready), 0);
        chk("dlo_rst_pause", 32'(cpu_pause), 1);
        chk("dlo_rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        bus_if.rx_valid = 1'b0;
        tick();
        chk("dlo_rst_no_write", 32'(wr_q.size()), 0);
        chk("dlo_rst_idle", 32'(busy), 0);

        // Randomized sessions against the session model
        for (int s = 0; s < 25; s++) begin
            addr = ($urandom_range(0, 1) == 1) ? 12'hFFF - 12'($urandom_range(0, 3)) : 12'($urandom);
            cnt  = 12'($urandom_range(0, 5));
            wq.delete();
            eq.delete();
            for (int i = 0; i < int'(cnt); i++) wq.push_back(16'($urandom));
            budget = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            stop_after = (budget == 16'd0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
            accum = 8'($urandom);
            for (int i = 0; i < int'(cnt); i++) eq.push_back({12'((int'(addr) + i) % 4096), wq[i]});
            do_session(100 + s, addr, cnt, wq, budget, stop_after, accum, 1'b1, eq,
                       model_run(int'(budget), stop_after), accum);
        end

        // Reset in the middle of an unbounded RUN
        wq.delete();
        wq.push_back(16'hCAFE);
        load_only(12'h010, 12'd1, wq, 16'd0, 8'h99, 1'b0);
        repeat (10) tick();
        chk("run_active", 32'(cpu_pause), 0);
        reset_n = 1'b0;
        tick();
        chk("run_rst_pause", 32'(cpu_pause), 1);
        chk("run_rst_cpu_reset", 32'(cpu_reset), 0);
        chk("run_rst_busy", 32'(busy), 0);
        chk("run_rst_done", 32'(done), 0);
        chk("run_rst_ready", 32'(bus_if.rx_ready), 0);
        chk("run_rst_write_en", 32'(bus_if.instr_write_en), 0);
        chk("run_rst_result", 32'(result), 0);
        reset_n = 1'b1;
        tick();

        // Recovery from IDLE with the reference stream
        wq.delete();
        eq.delete();
        wq.push_back(16'h4050);
        wq.push_back(16'h0101);
        eq.push_back({12'h000, 16'h4050});
        eq.push_back({12'h001, 16'h0101});
        do_session(200, 12'h000, 12'd2, wq, 16'd10, 0, 8'h42, 1'b0, eq, 10, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
